ccff_shadow_mem: RTL

Parametrised configuration-chain memory segment for routing-mux and LUT configuration. Bits shift in serially from `ccff_head` through a shift stage and continue to `ccff_tail`, so segments daisy-chain across the fabric. A separate shadow register drives `mem_out`/`mem_outb`, which change only on a validated `commit`. The fabric therefore never sees partially shifted configuration, and a segment can be reloaded while the fabric keeps running on the old configuration.

---
 rtl/ccff_pkg.sv | 15 +
 rtl/ccff_shift_stage.sv | 27 ++
 rtl/ccff_shadow_mem.sv | 100 ++++++++++
 3 files changed

// File: rtl/ccff_pkg.sv
// Shared types and helpers for the configuration-chain memory segment.
package ccff_pkg;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        LOADED  = 2'd2
    } ccff_state_e;

    // Bits needed to count 0..len inclusive.
    function automatic int cnt_width(input int len);
        return (len < 1) ? 1 : $clog2(len + 1);
    endfunction

endpackage

// File: rtl/ccff_shift_stage.sv
// Serial configuration shift stage; the tail is the last register bit, so the
// chain has no combinational path from head to tail.
module ccff_shift_stage #(
    parameter int LEN = 4
) (
    input  logic           prog_clk,
    input  logic           prog_reset,
    input  logic           ccff_head,
    input  logic           shift_en,
    output logic [0:LEN-1] sreg,
    output logic           ccff_tail
);

    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            sreg <= '0;
        end else if (shift_en) begin
            sreg[0] <= ccff_head;
            for (int i = 1; i < LEN; i++) begin
                sreg[i] <= sreg[i-1];
            end
        end
    end

    assign ccff_tail = sreg[LEN-1];

endmodule

// File: rtl/ccff_shadow_mem.sv
// Configuration memory segment: serial shift stage plus a shadow register that
// only updates on a validated commit, so the fabric never sees partial loads.
module ccff_shadow_mem
    import ccff_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int PARITY_EN = 0
) (
    input  logic             prog_clk,
    input  logic             prog_reset,
    input  logic             ccff_head,
    input  logic             shift_en,
    input  logic             commit,
    output logic             ccff_tail,
    output logic [0:WIDTH-1] mem_out,
    output logic [0:WIDTH-1] mem_outb,
    output logic             loaded,
    output logic             parity_ok,
    output logic             commit_err
);

    localparam int LEN = WIDTH + PARITY_EN;
    localparam int CW  = cnt_width(LEN);
    localparam logic [CW-1:0] CNT_MAX = CW'(LEN);

    logic [0:LEN-1]   sreg;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_next;
    ccff_state_e      state;
    logic             accept;
    logic             reject;
    logic [0:WIDTH-1] shadow;
    logic [0:WIDTH-1] shadow_b;

    ccff_shift_stage #(
        .LEN (LEN)
    ) u_shift (
        .prog_clk   (prog_clk),
        .prog_reset (prog_reset),
        .ccff_head  (ccff_head),
        .shift_en   (shift_en),
        .sreg       (sreg),
        .ccff_tail  (ccff_tail)
    );

    generate
        if (PARITY_EN != 0) begin : g_parity
            assign parity_ok = ~(^sreg);
        end else begin : g_no_parity
            assign parity_ok = 1'b1;
        end
    endgenerate

    // The FSM state is fully encoded by the bit counter.
    always_comb begin
        state = FILLING;
        if (cnt == '0) begin
            state = EMPTY;
        end else if (cnt == CNT_MAX) begin
            state = LOADED;
        end
    end

    assign loaded = (state == LOADED);

    // Commit sees the pre-shift chain; a same-cycle shift becomes the first bit
    // of the next load.
    always_comb begin
        accept   = commit && loaded && parity_ok;
        reject   = commit && !accept;
        cnt_next = cnt;
        if (accept) begin
            cnt_next = shift_en ? CW'(1) : '0;
        end else if (shift_en && (cnt != CNT_MAX)) begin
            cnt_next = cnt + 1'b1;
        end
    end

    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            cnt        <= '0;
            shadow     <= '0;
            shadow_b   <= '1;
            commit_err <= 1'b0;
        end else begin
            cnt <= cnt_next;
            if (accept) begin
                shadow   <= sreg[0:WIDTH-1];
                shadow_b <= ~sreg[0:WIDTH-1];
            end
            if (reject) begin
                commit_err <= 1'b1;
            end
        end
    end

    assign mem_out  = shadow;
    assign mem_outb = shadow_b;

endmodule
